// File: rtl/xb_pkg.sv
// Shared constants for the PC<->FPGA message bridge: default message width
// and the bit positions of the sticky error flags.
package xb_pkg;

  localparam int XB_SIZE_DEFAULT = 32;

  localparam int ERR_W        = 4;
  localparam int ERR_PC_OVF   = 0;
  localparam int ERR_PC_UDF   = 1;
  localparam int ERR_FPGA_OVF = 2;
  localparam int ERR_FPGA_UDF = 3;

endpackage

// File: rtl/xb_msg_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with a separately tracked count, registered
// flags, a full threshold lowered by SLACK, and overflow/underflow strobes.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int SLACK      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int FULL_TH = DEPTH - SLACK;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = FULL_TH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  wr_acc, rd_acc;
  logic                  full_q, empty_q;

  // Acceptance looks only at the registered count, so a pop cannot make room
  // for a push in the same cycle when the FIFO is completely full.
  always_comb begin
    wr_acc    = wr_en && (count < CNT_MAX);
    rd_acc    = rd_en && (count != '0);
    ovf       = wr_en && (count == CNT_MAX);
    udf       = rd_en && (count == '0);
    count_nxt = count + {{DEPTH_LOG2{1'b0}}, wr_acc} - {{DEPTH_LOG2{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      full_q  <= (count_nxt >= CNT_FULL);
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = count;

endmodule

// File: rtl/xb_msg_bridge.sv
// Host-side endpoint of the PC<->FPGA message channel: two independent
// show-ahead FIFOs plus sticky protocol-error flags.
module xb_msg_bridge
  import xb_pkg::*;
#(
  parameter int XB_SIZE    = XB_SIZE_DEFAULT,
  parameter int DEPTH_LOG2 = 4,
  parameter int SLACK      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_wr_en,
  input  logic [XB_SIZE-1:0]    pc_wr_data,
  output logic                  pc_wr_full,
  output logic                  pc_msg_empty,
  input  logic                  pc_msg_ack,
  output logic [XB_SIZE-1:0]    pc_msg,
  output logic                  fpga_msg_full,
  input  logic                  fpga_msg_valid,
  input  logic [XB_SIZE-1:0]    fpga_msg,
  output logic                  fpga_rd_empty,
  input  logic                  fpga_rd_en,
  output logic [XB_SIZE-1:0]    fpga_rd_data,
  output logic [DEPTH_LOG2:0]   pc_level,
  output logic [DEPTH_LOG2:0]   fpga_level,
  output logic [3:0]            err
);

  logic             pc_ovf, pc_udf, fpga_ovf, fpga_udf;
  logic [ERR_W-1:0] err_set, err_q;

  sync_fifo #(.WIDTH(XB_SIZE), .DEPTH_LOG2(DEPTH_LOG2), .SLACK(SLACK)) u_pc_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (pc_wr_en),
    .wr_data (pc_wr_data),
    .full    (pc_wr_full),
    .rd_en   (pc_msg_ack),
    .rd_data (pc_msg),
    .empty   (pc_msg_empty),
    .level   (pc_level),
    .ovf     (pc_ovf),
    .udf     (pc_udf)
  );

  sync_fifo #(.WIDTH(XB_SIZE), .DEPTH_LOG2(DEPTH_LOG2), .SLACK(SLACK)) u_fpga_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (fpga_msg_valid),
    .wr_data (fpga_msg),
    .full    (fpga_msg_full),
    .rd_en   (fpga_rd_en),
    .rd_data (fpga_rd_data),
    .empty   (fpga_rd_empty),
    .level   (fpga_level),
    .ovf     (fpga_ovf),
    .udf     (fpga_udf)
  );

  always_comb begin
    err_set               = '0;
    err_set[ERR_PC_OVF]   = pc_ovf;
    err_set[ERR_PC_UDF]   = pc_udf;
    err_set[ERR_FPGA_OVF] = fpga_ovf;
    err_set[ERR_FPGA_UDF] = fpga_udf;
  end

  // Error flags only ever set; reset is the sole way to clear them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_q | err_set;
  end

  assign err = err_q;

endmodule

// File: tb/tb_xb_msg_bridge.sv
// Self-checking bench for xb_msg_bridge: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_xb_msg_bridge;
  import xb_pkg::*;

  localparam int W     = 32;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int SLACK = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pc_wr_en = 1'b0, pc_msg_ack = 1'b0;
  logic          fpga_msg_valid = 1'b0, fpga_rd_en = 1'b0;
  logic [W-1:0]  pc_wr_data = '0, fpga_msg = '0;
  logic          pc_wr_full, pc_msg_empty, fpga_msg_full, fpga_rd_empty;
  logic [W-1:0]  pc_msg, fpga_rd_data;
  logic [DL:0]   pc_level, fpga_level;
  logic [3:0]    err;

  xb_msg_bridge #(.XB_SIZE(W), .DEPTH_LOG2(DL), .SLACK(SLACK)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_wr_en       (pc_wr_en),
    .pc_wr_data     (pc_wr_data),
    .pc_wr_full     (pc_wr_full),
    .pc_msg_empty   (pc_msg_empty),
    .pc_msg_ack     (pc_msg_ack),
    .pc_msg         (pc_msg),
    .fpga_msg_full  (fpga_msg_full),
    .fpga_msg_valid (fpga_msg_valid),
    .fpga_msg       (fpga_msg),
    .fpga_rd_empty  (fpga_rd_empty),
    .fpga_rd_en     (fpga_rd_en),
    .fpga_rd_data   (fpga_rd_data),
    .pc_level       (pc_level),
    .fpga_level     (fpga_level),
    .err            (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per direction, decisions taken on pre-edge occupancy.
  logic [W-1:0] pc_q[$];
  logic [W-1:0] f_q[$];
  logic [3:0]   m_err;

  task automatic model_edge();
    int pn, fn;
    pn = pc_q.size();
    fn = f_q.size();
    if (pc_msg_ack) begin
      if (pn == 0) m_err[ERR_PC_UDF] = 1'b1;
      else void'(pc_q.pop_front());
    end
    if (pc_wr_en) begin
      if (pn == DEPTH) m_err[ERR_PC_OVF] = 1'b1;
      else pc_q.push_back(pc_wr_data);
    end
    if (fpga_rd_en) begin
      if (fn == 0) m_err[ERR_FPGA_UDF] = 1'b1;
      else void'(f_q.pop_front());
    end
    if (fpga_msg_valid) begin
      if (fn == DEPTH) m_err[ERR_FPGA_OVF] = 1'b1;
      else f_q.push_back(fpga_msg);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " pc_level"}, 64'(pc_level), 64'(pc_q.size()));
    chk({tag, " pc_empty"}, 64'(pc_msg_empty), 64'(pc_q.size() == 0));
    chk({tag, " pc_full"}, 64'(pc_wr_full), 64'(pc_q.size() >= DEPTH - SLACK));
    if (pc_q.size() > 0) chk({tag, " pc_msg"}, 64'(pc_msg), 64'(pc_q[0]));
    chk({tag, " fpga_level"}, 64'(fpga_level), 64'(f_q.size()));
    chk({tag, " fpga_empty"}, 64'(fpga_rd_empty), 64'(f_q.size() == 0));
    chk({tag, " fpga_full"}, 64'(fpga_msg_full), 64'(f_q.size() >= DEPTH - SLACK));
    if (f_q.size() > 0) chk({tag, " fpga_data"}, 64'(fpga_rd_data), 64'(f_q[0]));
    chk({tag, " err"}, 64'(err), 64'(m_err));
  endtask

  task automatic idle_inputs();
    pc_wr_en = 1'b0; pc_msg_ack = 1'b0; fpga_msg_valid = 1'b0; fpga_rd_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string tag);
    model_edge();
    step();
    check_all(tag);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    pc_q.delete();
    f_q.delete();
    m_err = '0;
  endtask

  typedef struct {
    logic pw; logic [W-1:0] pd; logic pa;
    logic fv; logic [W-1:0] fd; logic fr;
    logic e_pe; int e_pl; logic [W-1:0] e_pm;
    logic e_fe; int e_fl; logic [W-1:0] e_fm;
    logic [3:0] e_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    // pw pd pa | fv fd fr | pc_empty pc_level pc_msg | f_empty f_level f_data | err
    vt[0] = '{1, 32'hA5A5A5A5, 0, 0, 32'h0,  0, 0, 1, 32'hA5A5A5A5, 1, 0, 32'h0,  4'b0000};
    vt[1] = '{0, 32'h0,        1, 0, 32'h0,  0, 1, 0, 32'h0,        1, 0, 32'h0,  4'b0000};
    vt[2] = '{1, 32'h33,       1, 0, 32'h0,  0, 0, 1, 32'h33,       1, 0, 32'h0,  4'b0010};
    vt[3] = '{0, 32'h0,        1, 0, 32'h0,  0, 1, 0, 32'h0,        1, 0, 32'h0,  4'b0010};
    vt[4] = '{0, 32'h0,        0, 1, 32'h11, 0, 1, 0, 32'h0,        0, 1, 32'h11, 4'b0010};
    vt[5] = '{0, 32'h0,        0, 1, 32'h22, 1, 1, 0, 32'h0,        0, 1, 32'h22, 4'b0010};
    vt[6] = '{0, 32'h0,        0, 0, 32'h0,  1, 1, 0, 32'h0,        1, 0, 32'h0,  4'b0010};
    vt[7] = '{0, 32'h0,        0, 0, 32'h0,  1, 1, 0, 32'h0,        1, 0, 32'h0,  4'b1010};

    do_reset();
    chk("reset pc_empty", 64'(pc_msg_empty), 64'd1);
    chk("reset fpga_empty", 64'(fpga_rd_empty), 64'd1);
    chk("reset pc_full", 64'(pc_wr_full), 64'd0);
    chk("reset fpga_full", 64'(fpga_msg_full), 64'd0);
    chk("reset levels", 64'({pc_level, fpga_level}), 64'd0);
    chk("reset err", 64'(err), 64'd0);

    for (int i = 0; i < 8; i++) begin
      pc_wr_en = vt[i].pw; pc_wr_data = vt[i].pd; pc_msg_ack = vt[i].pa;
      fpga_msg_valid = vt[i].fv; fpga_msg = vt[i].fd; fpga_rd_en = vt[i].fr;
      step();
      chk($sformatf("vec%0d pc_empty", i), 64'(pc_msg_empty), 64'(vt[i].e_pe));
      chk($sformatf("vec%0d pc_level", i), 64'(pc_level), 64'(vt[i].e_pl));
      if (!vt[i].e_pe) chk($sformatf("vec%0d pc_msg", i), 64'(pc_msg), 64'(vt[i].e_pm));
      chk($sformatf("vec%0d fpga_empty", i), 64'(fpga_rd_empty), 64'(vt[i].e_fe));
      chk($sformatf("vec%0d fpga_level", i), 64'(fpga_level), 64'(vt[i].e_fl));
      if (!vt[i].e_fe) chk($sformatf("vec%0d fpga_data", i), 64'(fpga_rd_data), 64'(vt[i].e_fm));
      chk($sformatf("vec%0d err", i), 64'(err), 64'(vt[i].e_err));
    end
    idle_inputs();

    // Fill the FPGA->host FIFO: full at 15, slack push at 16, overflow at 17.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fpga_msg_valid = 1'b1; fpga_msg = W'(i);
      tick("fill");
      chk($sformatf("fill%0d full", i), 64'(fpga_msg_full), 64'(i + 1 >= 15));
    end
    chk("fill16 err", 64'(err), 64'd0);
    fpga_msg = 32'hDEAD;
    tick("fill17");
    chk("fill17 err2", 64'(err[ERR_FPGA_OVF]), 64'd1);
    chk("fill17 level", 64'(fpga_level), 64'd16);
    fpga_msg_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d data", i), 64'(fpga_rd_data), 64'(i));
      fpga_rd_en = 1'b1;
      tick("drain");
    end
    fpga_rd_en = 1'b0;

    // Steady-state push+pop at level 5 across pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc_wr_en = 1'b1; pc_wr_data = 32'h100 + W'(i);
      tick("pre5");
    end
    for (int i = 0; i < 40; i++) begin
      pc_wr_en = 1'b1; pc_msg_ack = 1'b1; pc_wr_data = 32'h200 + W'(i);
      tick("wrap");
      chk($sformatf("wrap%0d level", i), 64'(pc_level), 64'd5);
    end
    pc_msg_ack = 1'b0;
    chk("wrap err", 64'(err), 64'd0);

    // At count 16 a simultaneous push+pop keeps the pop and drops the push.
    for (int i = 0; i < 11; i++) begin
      pc_wr_data = 32'h300 + W'(i);
      tick("to16");
    end
    chk("at16 level", 64'(pc_level), 64'd16);
    pc_msg_ack = 1'b1; pc_wr_data = 32'hBAD0;
    tick("full_pp");
    chk("full_pp level", 64'(pc_level), 64'd15);
    chk("full_pp err0", 64'(err[ERR_PC_OVF]), 64'd1);
    idle_inputs();

    // Reset mid-operation with 7 entries queued and an error latched.
    do_reset();
    pc_msg_ack = 1'b1;
    tick("pre_err");
    pc_msg_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pc_wr_en = 1'b1; pc_wr_data = 32'h400 + W'(i);
      fpga_msg_valid = 1'b1; fpga_msg = 32'h500 + W'(i);
      tick("q7");
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("midrst pc_empty", 64'(pc_msg_empty), 64'd1);
    chk("midrst pc_level", 64'(pc_level), 64'd0);
    chk("midrst fpga_empty", 64'(fpga_rd_empty), 64'd1);
    chk("midrst fpga_level", 64'(fpga_level), 64'd0);
    chk("midrst err", 64'(err), 64'd0);
    pc_q.delete(); f_q.delete(); m_err = '0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all("postrst");
    pc_wr_en = 1'b1; pc_wr_data = 32'h600D;
    tick("postrst_push");
    pc_wr_en = 1'b0;

    // Randomized traffic with phases biased toward filling and draining.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int ph, wp, rp;
      ph = (c / 150) % 3;
      wp = (ph == 0) ? 85 : (ph == 1) ? 20 : 50;
      rp = (ph == 0) ? 20 : (ph == 1) ? 85 : 50;
      pc_wr_en       = ($urandom_range(99) < wp);
      pc_wr_data     = $urandom;
      pc_msg_ack     = ($urandom_range(99) < rp);
      fpga_msg_valid = ($urandom_range(99) < wp);
      fpga_msg       = $urandom;
      fpga_rd_en     = ($urandom_range(99) < rp);
      tick("rnd");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xb_msg_bridge.md
# xb_msg_bridge

Host-side endpoint of the PC↔FPGA message channel. It is the other end of the application's `pc_msg` (empty/ack) and `fpga_msg` (full/valid) ports, and runs in the `bus_clk` domain.
- A host write port fills a show-ahead FIFO that the application drains through `pc_msg_empty`/`pc_msg_ack`/`pc_msg`.
- The application's `fpga_msg_valid`/`fpga_msg` writes fill a second FIFO that the host drains through a show-ahead read port.
- The block flags protocol violations in sticky error bits.

## Interface
- `XB_SIZE`, 32, message width in bits
- `DEPTH_LOG2`, 4, log2 of each FIFO's depth (DEPTH = 2**DEPTH_LOG2)
- `SLACK`, 1, entries kept free before the full flag asserts; absorbs writers with registered valid
- `clk`  in  1  sole clock. Connected to `bus_clk` at the top level.
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `pc_wr_en`  in  1  host pushes `pc_wr_data`
- `pc_wr_data`  in  XB_SIZE  host→FPGA message
- `pc_wr_full`  out  1  host must not push
- `pc_msg_empty`  out  1  no message available to the application
- `pc_msg_ack`  in  1  application pops the head entry
- `pc_msg`  out  XB_SIZE  head entry; valid whenever `pc_msg_empty`=0
- `fpga_msg_full`  out  1  application must not assert `fpga_msg_valid`
- `fpga_msg_valid`  in  1  application pushes `fpga_msg`
- `fpga_msg`  in  XB_SIZE  FPGA→host message
- `fpga_rd_empty`  out  1  nothing for the host
- `fpga_rd_en`  in  1  host pops the head entry
- `fpga_rd_data`  out  XB_SIZE  head entry; valid whenever `fpga_rd_empty`=0
- `pc_level`, `fpga_level`  out  DEPTH_LOG2+1  current occupancy
- `err`  out  4  sticky flags:
  - [0] pc overflow
  - [1] pc underflow
  - [2] fpga overflow
  - [3] fpga underflow

## Operation
- The two directions are identical and independent. Each is one `sync_fifo` instance plus error logic.
- Push is accepted iff `wr_en`=1 and count < DEPTH. Pop is accepted iff `rd_en`=1 and count > 0.
- Full flag = (count >= DEPTH−SLACK). Empty flag = (count == 0).
- Write while the full flag is set but count < DEPTH: accepted, no error. This is the slack.
- Write at count == DEPTH: dropped, and the overflow bit sets.
- Read at count == 0: ignored, and the underflow bit sets. A write in the same cycle is still accepted.
- Simultaneous push and pop:
  - 0 < count < DEPTH: both happen and count is unchanged.
  - count == DEPTH: the pop happens and the push is dropped (overflow), because acceptance uses the registered count.
- Read data is show-ahead. The head entry is presented combinationally from RAM at `rd_ptr`. A pop advances `rd_ptr` and the next entry appears the following cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Count is tracked separately in DEPTH_LOG2+1 bits.
- `err` bits are set-only until `reset`.

## Timing
- Reset values (asserted asynchronously, released synchronously):
  - all pointers and counts 0
  - `pc_msg_empty`=1, `fpga_rd_empty`=1
  - `pc_wr_full`=0, `fpga_msg_full`=0
  - `err`=0, levels 0
  - data outputs are don't-care
- Flags and levels are registered and update on the edge after the accepted operation.
- Write-to-read latency is 1 cycle. A push at edge N clears empty after edge N, and the data is on the read port in cycle N+1.
- Reset mid-operation empties both FIFOs immediately. In-flight messages are discarded with no error.
- RAM is not reset.

## Structure
- Shared package `xb_pkg`: `XB_SIZE` default and the `ERR_*` bit-index constants, used by `application` and by the bench.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH_LOG2`, `SLACK`):
  - contains the RAM, pointers, count, flags and overflow/underflow strobes
  - instantiated twice
  - `xb_msg_bridge` holds only the sticky error registers and port mapping

## Test plan
- After reset, push 0xA5A5A5A5 on the host side → `pc_msg_empty` drops the next cycle with `pc_msg`=0xA5A5A5A5. `pc_msg_ack` restores empty, `err`=0.
- Application pushes 16 values 0..15 (DEPTH 16) → `fpga_msg_full` rises at `fpga_level`=15. The 16th push is accepted with no error. A 17th push sets `err[2]`, and the host reads back exactly 0..15 in order.
- Pop an empty FIFO via `pc_msg_ack` → `err[1]`=1 and stays set. Level remains 0.
- With `pc_level`=5, assert `pc_wr_en` and `pc_msg_ack` together for 40 cycles → level stays 5, data stays in order across pointer wrap, no errors.
- At count 16, push and pop together → pop succeeds, push is dropped, `err[2]` or `err[0]` sets, level becomes 15.
- Deassert `reset` (drive 0) with 7 entries queued → within the same cycle empty=1, level=0, `err`=0, and queued data is not presented after reset releases.
